// File: rtl/frame2axi_stream_if.sv
// Handshake bundles for frame2axi_stream: the frame-style pixel input
// and the AXI4-Stream video output.
interface frame2axi_stream_frm_if #(
    parameter int DATA_WIDTH = 24
);
    logic                  val;
    logic                  rdy;
    logic [DATA_WIDTH-1:0] data;
    logic                  sof;
    logic                  eof;
    logic                  sol;
    logic                  eol;

    modport master (
        output val, data, sof, eof, sol, eol,
        input  rdy
    );

    modport slave (
        input  val, data, sof, eof, sol, eol,
        output rdy
    );
endinterface

interface frame2axi_stream_axis_if #(
    parameter int DATA_WIDTH = 24
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tuser;
    logic                  tlast;

    modport master (
        output tvalid, tdata, tuser, tlast,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tuser, tlast,
        output tready
    );
endinterface

// File: rtl/frame2axi_stream.sv
// Frame-marker pixel stream to AXI4-Stream video bridge with a skid buffer.
// Define FRAME2AXIS_GEOM_CHK_EN to add the err_geom geometry checker.
module frame2axi_stream #(
    parameter int DATA_WIDTH = 24
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [11:0]                    cfg_img_w,
    input  logic [11:0]                    cfg_img_h,
    frame2axi_stream_frm_if.slave          s_frm,
    frame2axi_stream_axis_if.master        m_axi_stream
`ifdef FRAME2AXIS_GEOM_CHK_EN
    ,
    output logic                           err_geom
`endif
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  sof;
        logic                  eol;
    } beat_t;

    state_t state_q, state_d;
    beat_t  out_q, out_d;
    beat_t  skid_q, skid_d;
    beat_t  in_beat;
    logic   out_v_q, out_v_d;
    logic   skid_v_q, skid_v_d;
    logic   rdy_q, rdy_d;
    logic   acc;
    logic   fwd;
    logic   out_rdy;

    assign acc     = s_frm.val & rdy_q;
    assign fwd     = acc & (s_frm.sof | (state_q == ACTIVE));
    assign out_rdy = ~out_v_q | m_axi_stream.tready;

    assign s_frm.rdy           = rdy_q;
    assign m_axi_stream.tvalid = out_v_q;
    assign m_axi_stream.tdata  = out_q.data;
    assign m_axi_stream.tuser  = out_q.sof;
    assign m_axi_stream.tlast  = out_q.eol;

    always_comb begin
        state_d = state_q;
        if (acc) begin
            unique case (1'b1)
                s_frm.sof & s_frm.eof:
                    state_d = IDLE;
                s_frm.sof & ~s_frm.eof:
                    state_d = ACTIVE;
                ~s_frm.sof & s_frm.eof & (state_q == ACTIVE):
                    state_d = IDLE;
                default: ;
            endcase
        end
    end

    // Skid only fills while the output register is stalled, so rdy
    // depends on registered state alone.
    always_comb begin
        in_beat.data = s_frm.data;
        in_beat.sof  = s_frm.sof;
        in_beat.eol  = s_frm.eol;
        out_d        = out_q;
        out_v_d      = out_v_q;
        skid_d       = skid_q;
        skid_v_d     = skid_v_q;
        if (out_rdy) begin
            if (skid_v_q) begin
                out_d    = skid_q;
                out_v_d  = 1'b1;
                skid_v_d = 1'b0;
            end else begin
                out_v_d = fwd;
                if (fwd) begin
                    out_d = in_beat;
                end
            end
        end else if (fwd) begin
            skid_d   = in_beat;
            skid_v_d = 1'b1;
        end
        rdy_d = ~skid_v_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            out_q    <= '0;
            out_v_q  <= 1'b0;
            skid_q   <= '0;
            skid_v_q <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            out_v_q  <= out_v_d;
            skid_q   <= skid_d;
            skid_v_q <= skid_v_d;
            rdy_q    <= rdy_d;
        end
    end

`ifdef FRAME2AXIS_GEOM_CHK_EN
    logic [11:0] pix_q, pix_d;
    logic [11:0] line_q, line_d;
    logic [11:0] pix_n;
    logic [11:0] line_n;
    logic        eol_seen_q, eol_seen_d;
    logic        err_q, err_d;
    logic        bad_w;
    logic        bad_h;
    logic        bad_sol;

    assign err_geom = err_q;

    // Counts are 1-based for the beat being checked; SOF restarts them.
    always_comb begin
        pix_d      = pix_q;
        line_d     = line_q;
        eol_seen_d = eol_seen_q;
        err_d      = err_q;
        pix_n      = (s_frm.sof ? 12'd0 : pix_q) + 12'd1;
        line_n     = s_frm.sof ? 12'd0 : line_q;
        bad_w      = s_frm.eol & (pix_n != cfg_img_w);
        bad_h      = s_frm.eof & ((line_n + 12'd1) != cfg_img_h);
        bad_sol    = (state_q == ACTIVE) & ~s_frm.sof
                   & s_frm.sol & ~eol_seen_q;
        if (fwd) begin
            pix_d      = s_frm.eol ? 12'd0 : pix_n;
            line_d     = s_frm.eol ? (line_n + 12'd1) : line_n;
            eol_seen_d = s_frm.eol;
            err_d      = (s_frm.sof ? 1'b0 : err_q)
                       | bad_w | bad_h | bad_sol;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_q      <= '0;
            line_q     <= '0;
            eol_seen_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            pix_q      <= pix_d;
            line_q     <= line_d;
            eol_seen_q <= eol_seen_d;
            err_q      <= err_d;
        end
    end
`else
    logic unused_geom;
    assign unused_geom = ^{cfg_img_w, cfg_img_h, s_frm.sol};
`endif

endmodule

// File: tb/tb_frame2axi_stream.sv
// Randomised bench for frame2axi_stream against a frame-level model.
// Build with FRAME2AXIS_GEOM_CHK_EN to also exercise err_geom.
module tb_frame2axi_stream;

    localparam int DW = 24;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] cfg_w = 12'd4;
    logic [11:0] cfg_h = 12'd2;
`ifdef FRAME2AXIS_GEOM_CHK_EN
    logic        err_geom;
`endif

    frame2axi_stream_frm_if  #(.DATA_WIDTH(DW)) frm ();
    frame2axi_stream_axis_if #(.DATA_WIDTH(DW)) axs ();

    frame2axi_stream #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_img_w    (cfg_w),
        .cfg_img_h    (cfg_h),
        .s_frm        (frm),
        .m_axi_stream (axs)
`ifdef FRAME2AXIS_GEOM_CHK_EN
        ,
        .err_geom     (err_geom)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          sof;
        logic          eof;
        logic          sol;
        logic          eol;
    } beat_t;

    typedef struct {
        logic [DW-1:0] d;
        logic          user;
        logic          last;
    } exp_t;

    beat_t         stim[$];
    exp_t          expq[$];
    int            n_chk = 0;
    int            n_fail = 0;
    int            outstanding = 0;
    int            n_out = 0;
    bit            in_frame = 0;
    bit            in_x = 0;
    bit            stalled = 0;
    int            mode = 0;
    int            gap_pct = 0;
    logic [DW-1:0] h_d;
    logic          h_u;
    logic          h_l;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_beat(int d, bit sof, bit eof, bit sol, bit eol);
        beat_t b;
        b.d   = DW'(d);
        b.sof = sof;
        b.eof = eof;
        b.sol = sol;
        b.eol = eol;
        stim.push_back(b);
    endtask

    // base 0 -> random pixel data; keep < 0 -> whole frame
    task automatic add_frame(int w, int h, int base, int keep);
        int n;
        n = 0;
        for (int l = 0; l < h; l++) begin
            for (int p = 0; p < w; p++) begin
                if (keep < 0 || n < keep) begin
                    add_beat(base == 0 ? int'($urandom) : base + n,
                             (l == 0) && (p == 0),
                             (l == h - 1) && (p == w - 1),
                             p == 0, p == w - 1);
                end
                n++;
            end
        end
    endtask

    task automatic add_junk(int n);
        for (int i = 0; i < n; i++) begin
            add_beat(int'($urandom), 1'b0, $urandom_range(1) == 1,
                     $urandom_range(1) == 1, $urandom_range(1) == 1);
        end
    endtask

    task automatic model_clear();
        expq.delete();
        outstanding = 0;
        in_frame    = 0;
        in_x        = 0;
        stalled     = 0;
        frm.val     = 1'b0;
    endtask

    task automatic step();
        beat_t b;
        exp_t  e;
        @(posedge clk);
        #1;
        chk("tvalid", axs.tvalid, outstanding > 0);
        chk("s_frm_rdy", frm.rdy, outstanding < 2);
        if (stalled) begin
            chk("hold_tdata", axs.tdata, h_d);
            chk("hold_tuser", axs.tuser, h_u);
            chk("hold_tlast", axs.tlast, h_l);
        end
        if (in_x || !frm.val) begin
            if (stim.size() > 0 && $urandom_range(99) >= gap_pct) begin
                b = stim.pop_front();
                frm.val  = 1'b1;
                frm.data = b.d;
                frm.sof  = b.sof;
                frm.eof  = b.eof;
                frm.sol  = b.sol;
                frm.eol  = b.eol;
            end else begin
                frm.val = 1'b0;
            end
        end
        case (mode)
            0: axs.tready = 1'b1;
            1: axs.tready = ~axs.tready;
            2: axs.tready = $urandom_range(1) == 1;
            default: axs.tready = 1'b0;
        endcase
        in_x = frm.val & frm.rdy;
        if (axs.tvalid && axs.tready) begin
            n_out++;
            chk("beat_expected", expq.size() != 0, 1'b1);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("tdata", axs.tdata, e.d);
                chk("tuser", axs.tuser, e.user);
                chk("tlast", axs.tlast, e.last);
            end
            outstanding--;
        end
        stalled = axs.tvalid & ~axs.tready;
        h_d = axs.tdata;
        h_u = axs.tuser;
        h_l = axs.tlast;
        if (in_x && (frm.sof || in_frame)) begin
            e.d    = frm.data;
            e.user = frm.sof;
            e.last = frm.eol;
            expq.push_back(e);
            outstanding++;
            in_frame = !frm.eof;
        end
    endtask

    task automatic run(int budget);
        int cyc;
        cyc = 0;
        while (cyc < budget &&
               !(stim.size() == 0 && (!frm.val || in_x) &&
                 outstanding == 0)) begin
            step();
            cyc++;
        end
        @(negedge clk);
        frm.val = 1'b0;
        in_x    = 0;
        chk("drained", outstanding + stim.size(), 0);
    endtask

    initial begin
        beat_t rest[$];
        int    w;
        int    h;
        frm.val    = 1'b0;
        frm.data   = '0;
        frm.sof    = 1'b0;
        frm.eof    = 1'b0;
        frm.sol    = 1'b0;
        frm.eol    = 1'b0;
        axs.tready = 1'b0;

        #12;
        chk("rst_rdy", frm.rdy, 1'b0);
        chk("rst_tvalid", axs.tvalid, 1'b0);
        chk("rst_tdata", axs.tdata, 0);
        chk("rst_tuser", axs.tuser, 1'b0);
        chk("rst_tlast", axs.tlast, 1'b0);
`ifdef FRAME2AXIS_GEOM_CHK_EN
        chk("rst_err_geom", err_geom, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // 4x2 frame, data 1..8, tready high
        mode = 0;
        gap_pct = 0;
        n_out = 0;
        add_frame(4, 2, 1, -1);
        run(100);
        chk("frame_beats", n_out, 8);

        // same frame with tready toggling
        mode = 1;
        n_out = 0;
        add_frame(4, 2, 1, -1);
        run(100);
        chk("toggle_beats", n_out, 8);

        // three beats outside a frame then a 2x1 frame
        mode = 0;
        n_out = 0;
        add_beat(100, 0, 0, 1, 0);
        add_beat(101, 0, 1, 0, 1);
        add_beat(102, 0, 0, 0, 0);
        add_frame(2, 1, 200, -1);
        run(100);
        chk("drop_beats", n_out, 2);

        // reset mid-frame with output stalled
        mode = 3;
        add_frame(4, 2, 1, -1);
        for (int i = 0; i < 5; i++) step();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_tvalid", axs.tvalid, 1'b0);
        chk("midrst_rdy", frm.rdy, 1'b0);
        chk("midrst_tuser", axs.tuser, 1'b0);
        rest = stim;
        stim.delete();
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stim = rest;
        mode = 0;
        n_out = 0;
        add_frame(4, 2, 50, -1);
        run(200);
        chk("post_rst_beats", n_out, 8);

`ifdef FRAME2AXIS_GEOM_CHK_EN
        cfg_w = 12'd4;
        cfg_h = 12'd2;
        add_beat(1, 1, 0, 1, 0);
        add_beat(2, 0, 0, 0, 0);
        add_beat(3, 0, 0, 0, 1);
        add_beat(4, 0, 0, 1, 0);
        add_beat(5, 0, 0, 0, 0);
        add_beat(6, 0, 0, 0, 0);
        add_beat(7, 0, 1, 0, 1);
        run(100);
        chk("err_geom_short", err_geom, 1'b1);
        add_frame(4, 2, 10, -1);
        run(100);
        chk("err_geom_clean", err_geom, 1'b0);
`endif

        // random frames, junk, truncation, gaps and backpressure
        for (int it = 0; it < 40; it++) begin
            mode    = $urandom_range(2);
            gap_pct = $urandom_range(50);
            w = $urandom_range(1, 5);
            h = $urandom_range(1, 3);
            cfg_w = 12'(w);
            cfg_h = 12'(h);
            add_junk($urandom_range(3));
            if ($urandom_range(3) == 0) begin
                add_frame(w, h, 0, $urandom_range(1, w * h));
            end
            add_frame(w, h, 0, -1);
            run(400);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/frame2axi_stream.md
FRAME2AXI_STREAM -- requirements
Module: frame2axi_stream

Interface
REQ-001 Parameter: DATA_WIDTH, default 24, pixel data width in bits.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst_n  input  1  asynchronous reset, active low.
REQ-004 cfg_img_w  input  12  image width in pixels; static while a frame is active.
REQ-005 cfg_img_h  input  12  image height in lines; static while a frame is active.
REQ-006 s_frm_val  input  1  frame master has a valid beat.
REQ-007 s_frm_rdy  output  1  block accepts a beat; registered.
REQ-008 s_frm_data  input  DATA_WIDTH  pixel data.
REQ-009 s_frm_sof / s_frm_eof / s_frm_sol / s_frm_eol  input  1 each  start/end of frame, start/end of line, qualified by s_frm_val.
REQ-010 m_axi_stream_tvalid  output  1  stream beat valid.
REQ-011 m_axi_stream_tready  input  1  downstream ready.
REQ-012 m_axi_stream_tdata  output  DATA_WIDTH  pixel data.
REQ-013 m_axi_stream_tuser  output  1  start of frame (first pixel).
REQ-014 m_axi_stream_tlast  output  1  end of line (last pixel of each line).

Function
REQ-015 Input transfer on s_frm_val & s_frm_rdy; output transfer on m_axi_stream_tvalid & m_axi_stream_tready.
REQ-016 Datapath is a two-register skid buffer (output register + skid register), each holding {data, sof, eol}.
REQ-017 s_frm_rdy SHALL be high exactly when the skid register is empty; no combinational path from m_axi_stream_tready to s_frm_rdy.
REQ-018 Latency: a beat accepted in cycle N SHALL appear on m_axi_stream_* in cycle N+1 when the output register is empty or drains in cycle N.
REQ-019 Sustained throughput: one beat per cycle while m_axi_stream_tready is high.
REQ-020 Stalled output (tvalid & ~tready) SHALL hold tdata, tuser, tlast, tvalid stable.
REQ-021 tuser SHALL equal the beat's s_frm_sof; tlast SHALL equal the beat's s_frm_eol; s_frm_sol is ignored on the datapath.
REQ-022 FSM states: IDLE (waiting for SOF), ACTIVE (in frame).
REQ-023 IDLE: beats without s_frm_sof are accepted and discarded; a beat with s_frm_sof is forwarded, go ACTIVE.
REQ-024 ACTIVE: all beats forwarded; an accepted beat with s_frm_eof returns to IDLE after being forwarded.
REQ-025 SOF+EOF on the same beat (1x1 frame): forwarded with tuser=1, tlast=eol, FSM stays IDLE.
REQ-026 SOF in ACTIVE (truncated frame): forwarded with tuser=1, FSM stays ACTIVE, new frame starts.
REQ-027 Beat ordering SHALL be preserved; no beat duplicated or lost except per REQ-023.

Reset
REQ-028 Reset: tvalid=0, tdata=0, tuser=0, tlast=0, skid register empty, FSM=IDLE, counters=0.
REQ-029 s_frm_rdy SHALL be 0 while rst_n is low and 1 in the first cycle after deassertion.
REQ-030 Reset mid-frame discards all buffered beats; after reset, output resumes only at the next SOF.

Configuration
REQ-031 Macro FRAME2AXIS_GEOM_CHK_EN: when defined, adds output err_geom (1 bit, reset 0) and 12-bit pixel and line counters on forwarded input beats.
REQ-032 With the macro defined, err_geom SHALL set (sticky until the next accepted SOF) when an EOL beat's pixel count != cfg_img_w, or an EOF beat's line count != cfg_img_h, or a beat in ACTIVE has s_frm_sol without a preceding EOL.
REQ-033 Without the macro: no err_geom port and no counters; datapath behaviour identical.

Verification
REQ-034 4x2 frame (DATA_WIDTH=24, data 1..8), tready=1 -> 8 beats back to back, tuser only on data 1, tlast on data 4 and 8, first tvalid 1 cycle after first accept.
REQ-035 Same frame, tready toggling 1/0 each cycle -> identical beat sequence, outputs stable during stalls, s_frm_rdy low only while the skid register is full.
REQ-036 3 beats without SOF then a 2x1 frame -> first 3 dropped, exactly 2 beats output, tuser on the first.
REQ-037 rst_n pulsed low after 3 beats of a 4x2 frame, tready=0 -> tvalid=0 immediately, no stale beat emitted, next frame clean.
REQ-038 FRAME2AXIS_GEOM_CHK_EN, cfg 4x2, first line has 3 pixels -> err_geom=1 after the EOL beat, cleared on next SOF; correct 4x2 frame keeps err_geom=0.
